// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) round-robin arbiter onto a
// single shared memory request port. Each transaction is latched on grant,
// presented to memory while BUSY, and acknowledged for one DONE cycle. A
// stall counter aborts a transaction stuck on mem_waitrequest and raises a
// sticky err flag.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  // data port
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  // shared memory port
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        err
);

  // Counter must be able to hold the value TIMEOUT itself.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t          state_q;
  logic            last_grant_q;
  logic [CW-1:0]   stall_q;
  logic            err_q;
  logic [31:0]     i_readdata_q;
  logic [31:0]     d_readdata_q;
  logic [31:0]     mem_address_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic [31:0]     mem_writedata_q;
  logic [3:0]      mem_byteenable_q;

  logic            i_pend_d;
  logic            d_pend_d;
  logic            grant_i_d;
  logic            grant_d_d;
  logic [CW-1:0]   stall_inc_d;
  logic            timeout_hit_d;

  // Arbitration decision and stall-limit detection for the next FSM edge
  always_comb begin
    i_pend_d      = i_read;
    d_pend_d      = d_read | d_write;
    grant_i_d     = 1'b0;
    grant_d_d     = 1'b0;
    if (i_pend_d && d_pend_d) begin
      // tie: whoever was not served last goes first
      if (last_grant_q == GRANT_D) begin
        grant_i_d = 1'b1;
      end else begin
        grant_d_d = 1'b1;
      end
    end else if (i_pend_d) begin
      grant_i_d = 1'b1;
    end else if (d_pend_d) begin
      grant_d_d = 1'b1;
    end else begin
      grant_i_d = 1'b0;
      grant_d_d = 1'b0;
    end
    stall_inc_d   = stall_q + CW'(1);
    timeout_hit_d = (stall_inc_d == CW'(TIMEOUT));
  end

  // Transaction FSM: grant, latch request, drive memory, capture/abort, acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      last_grant_q     <= GRANT_D;
      stall_q          <= '0;
      err_q            <= 1'b0;
      i_readdata_q     <= 32'h0000_0000;
      d_readdata_q     <= 32'h0000_0000;
      mem_address_q    <= 32'h0000_0000;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= 32'h0000_0000;
      mem_byteenable_q <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i_d) begin
            state_q          <= BUSY_I;
            last_grant_q     <= GRANT_I;
            stall_q          <= '0;
            mem_address_q    <= i_address;
            mem_read_q       <= 1'b1;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= 32'h0000_0000;
            mem_byteenable_q <= 4'b1111;
          end else if (grant_d_d) begin
            state_q          <= BUSY_D;
            last_grant_q     <= GRANT_D;
            stall_q          <= '0;
            mem_address_q    <= d_address;
            // read+write together is a write
            mem_read_q       <= ~d_write;
            mem_write_q      <= d_write;
            mem_writedata_q  <= d_writedata;
            mem_byteenable_q <= d_byteenable;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY_I: begin
          if (!mem_waitrequest) begin
            i_readdata_q     <= mem_readdata;
            state_q          <= DONE_I;
            mem_address_q    <= 32'h0000_0000;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= 32'h0000_0000;
            mem_byteenable_q <= 4'b0000;
          end else if (timeout_hit_d) begin
            i_readdata_q     <= ABORT_DATA;
            err_q            <= 1'b1;
            stall_q          <= stall_inc_d;
            state_q          <= DONE_I;
            mem_address_q    <= 32'h0000_0000;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= 32'h0000_0000;
            mem_byteenable_q <= 4'b0000;
          end else begin
            stall_q <= stall_inc_d;
          end
        end
        BUSY_D: begin
          if (!mem_waitrequest) begin
            // stores leave the load-data register untouched
            if (mem_read_q) begin
              d_readdata_q <= mem_readdata;
            end else begin
              d_readdata_q <= d_readdata_q;
            end
            state_q          <= DONE_D;
            mem_address_q    <= 32'h0000_0000;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= 32'h0000_0000;
            mem_byteenable_q <= 4'b0000;
          end else if (timeout_hit_d) begin
            if (mem_read_q) begin
              d_readdata_q <= ABORT_DATA;
            end else begin
              d_readdata_q <= d_readdata_q;
            end
            err_q            <= 1'b1;
            stall_q          <= stall_inc_d;
            state_q          <= DONE_D;
            mem_address_q    <= 32'h0000_0000;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= 32'h0000_0000;
            mem_byteenable_q <= 4'b0000;
          end else begin
            stall_q <= stall_inc_d;
          end
        end
        DONE_I: begin
          state_q <= IDLE;
        end
        DONE_D: begin
          state_q <= IDLE;
        end
        default: begin
          state_q          <= IDLE;
          mem_read_q       <= 1'b0;
          mem_write_q      <= 1'b0;
          mem_byteenable_q <= 4'b0000;
        end
      endcase
    end
  end

  // A requester stalls for as long as it asks, except in its own DONE cycle.
  assign i_waitrequest  = i_pend_d & (state_q != DONE_I);
  assign d_waitrequest  = d_pend_d & (state_q != DONE_D);

  assign i_readdata     = i_readdata_q;
  assign d_readdata     = d_readdata_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_byteenable_q;
  assign err            = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of consecutive stalled memory cycles before a transaction is aborted.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports i_address (input, 32, instruction fetch byte address), i_read (input, 1, fetch request), i_waitrequest (output, 1, fetch stall) and i_readdata (output, 32, fetched word).
REQ-005 The block SHALL have ports d_address (input, 32, data byte address), d_read (input, 1, data read request) and d_write (input, 1, data write request).
REQ-006 The block SHALL have ports d_writedata (input, 32, store word), d_byteenable (input, 4, byte lanes), d_waitrequest (output, 1, data stall) and d_readdata (output, 32, load word).
REQ-007 The block SHALL have ports mem_address (output, 32), mem_read (output, 1), mem_write (output, 1), mem_writedata (output, 32) and mem_byteenable (output, 4), forming the shared memory request.
REQ-008 The block SHALL have ports mem_readdata (input, 32, memory read data), mem_waitrequest (input, 1, memory stall) and err (output, 1, sticky timeout flag).

Function
REQ-009 The FSM SHALL have states IDLE, BUSY_I, BUSY_D, DONE_I and DONE_D.
REQ-010 In IDLE, a pending request (i_read, or d_read|d_write) SHALL latch that requester's address, writedata, byteenable and kind and move to BUSY_x at the next edge.
REQ-011 When both requesters are pending in IDLE, the grant SHALL go to the requester not granted last (round-robin via 1-bit last_grant, updated on every grant).
REQ-012 In BUSY_x, mem_* outputs SHALL be driven from the latched request; in every other state, mem_read=mem_write=0 and mem_byteenable=0.
REQ-013 Instruction transactions SHALL drive mem_byteenable=4'b1111 and mem_write=0.
REQ-014 d_read and d_write asserted together SHALL be treated as a write.
REQ-015 In BUSY_x with mem_waitrequest=0, the FSM SHALL capture mem_readdata into x_readdata (reads only) and go to DONE_x.
REQ-016 In DONE_x, x_waitrequest SHALL be 0 for exactly that one cycle, then the FSM SHALL return to IDLE.
REQ-017 Minimum latency SHALL be: request seen in cycle 0, mem access in cycle 1, waitrequest low in cycle 2; each memory stall cycle adds one cycle.
REQ-018 x_waitrequest SHALL equal x's request OR'd together AND NOT (state==DONE_x), so an idle requester sees 0.
REQ-019 d_readdata SHALL be unchanged by write transactions; x_readdata SHALL hold its value between transactions.
REQ-020 Requester input changes or request deassertion during BUSY_x SHALL be ignored; the latched transaction SHALL complete.
REQ-021 A stall counter SHALL increment each BUSY cycle with mem_waitrequest=1, SHALL clear on entry to BUSY, and SHALL be wide enough for TIMEOUT.
REQ-022 When the stall counter reaches TIMEOUT, the FSM SHALL go to DONE_x, load x_readdata=32'hDEADBEEF on reads, and set err.
REQ-023 err SHALL remain set until reset.
REQ-024 Addresses SHALL be passed through unmodified, with no alignment check.
REQ-025 A requester SHALL NOT be granted twice in a row while the other is pending.

Reset
REQ-026 Reset SHALL force IDLE, last_grant=D (first tie goes to I), stall counter=0, err=0, i_readdata=d_readdata=0 and all mem_* outputs 0.
REQ-027 Reset asserted during BUSY_x SHALL abandon the transaction, with mem_read/mem_write low in the cycle after the reset edge.

Verification
REQ-028 i_read=1, i_address=0xBFC00000, memory returns 0x3C011000 with no stall -> mem_read high in cycle 1, i_waitrequest low in cycle 2, i_readdata=0x3C011000.
REQ-029 d_write=1, d_address=0x10000004, d_writedata=0xAABBCCDD, be=4'b0011 -> mem_write=1 with the same address/data/be for one cycle, and d_readdata unchanged.
REQ-030 i_read and d_read both held high from reset, zero-stall memory -> grant order I, D, I, D, and neither waitrequest goes low out of turn.
REQ-031 mem_waitrequest held high for 3 cycles on a d_read -> d_waitrequest low in cycle 5, and err stays 0.
REQ-032 mem_waitrequest stuck high with TIMEOUT=16 -> DONE after 16 stall cycles, d_readdata=0xDEADBEEF, err=1 until reset.
REQ-033 Reset asserted in BUSY_I -> mem_read=0 next cycle, FSM in IDLE, and the next tie grants I.
